register_file_sb: RTL and testbench
===================================

// Module: register_file_sb
// PURPOSE
//  Parametrised next-generation integer register file for the pipelined RISC-V core.
//  Two combinational read ports, one synchronous write port, hardwired-zero x0 and optional write-to-read bypass.
//  Adds a per-register pending scoreboard for hazard detection, plus a 4-phase debug access port for halt-mode reads/writes.
//  Sits between decode (RA1/RA2/issue) and write-back (WE3/WA3/WD3).
// PARAMETERS
//  XLEN    32  data width of each register
//  NREGS   32  number of architectural registers (power of two, >=2)
//  AW      5   address width, = $clog2(NREGS)
//  BYPASS  1   1: same-cycle write data forwarded to read ports; 0: read returns stored value
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     asynchronous, active-high reset
//  RA1, RA2   in   AW    read addresses
//  RD1, RD2   out  XLEN  read data (combinational)
//  BUSY1/2    out  1     register at RA1/RA2 has an outstanding producer
//  WE3        in   1     write enable (write-back stage)
//  WA3        in   AW    write address
//  WD3        in   XLEN  write data
//  ISSUE_EN   in   1     instruction issued that will write ISSUE_RD
//  ISSUE_RD   in   AW    destination register of issued instruction
//  DBG_REQ    in   1     debug request, held until DBG_ACK seen
//  DBG_WE     in   1     1 = debug write, 0 = debug read (stable while DBG_REQ)
//  DBG_ADDR   in   AW    debug register address
//  DBG_WDATA  in   XLEN  debug write data
//  DBG_ACK    out  1     debug access complete
//  DBG_RDATA  out  XLEN  debug read data, valid while DBG_ACK=1
// BEHAVIOUR
//  Reset: all registers 0, pending[] 0, FSM IDLE, DBG_ACK 0, DBG_RDATA 0; takes effect immediately, mid-access included.
//  Reads: RDx = (RAx==0) ? 0 : (BYPASS && WE3 && WA3==RAx) ? WD3 : regs[RAx]. Zero-cycle latency.
//  Write: on posedge, if WE3 && WA3!=0 then regs[WA3] <= WD3. Writes to x0 discarded.
//  Scoreboard: posedge: WE3 clears pending[WA3]; ISSUE_EN sets pending[ISSUE_RD]; set wins when both hit the same register.
//   ISSUE_RD==0 never sets; pending[0] is constant 0.
//  BUSYx = pending[RAx] & ~(BYPASS && WE3 && WA3==RAx && !(ISSUE_EN && ISSUE_RD==RAx)).
//  Debug FSM (4-phase handshake), states IDLE, ACCESS, DONE:
//   IDLE   -> ACCESS when DBG_REQ=1.
//   ACCESS: if DBG_WE && WE3, stay (core write port has priority).
//           Otherwise perform the access: write regs[DBG_ADDR] (ignored if addr 0) or capture DBG_RDATA = stored regs[DBG_ADDR] (no bypass).
//           Assert DBG_ACK next cycle -> DONE.
//   DONE:  DBG_ACK=1, DBG_RDATA held; DBG_REQ=0 -> IDLE, DBG_ACK=0 next cycle.
//   Debug read never stalls. Debug write does not alter pending[].
//   DBG_REQ dropped in ACCESS before completion: access aborted, -> IDLE, no write.
//  Simultaneous core and debug write to the same register in one cycle cannot occur (stall rule).
// STRUCTURE
//  Package rf_pkg: XLEN/NREGS defaults, dbg_state_t enum {IDLE, ACCESS, DONE}.
//  Sub-module rf_dbg_ctrl: debug FSM. Outputs dbg_wr_en, dbg_rd_cap, DBG_ACK.
//  Storage array, bypass muxes and scoreboard live in the top.
// TESTING
//  1 Reset mid-run: write x5=0xDEAD, assert rst -> RD1(RA1=5)=0, BUSY1=0, DBG_ACK=0 without waiting for a clock.
//  2 Write/read with bypass: WE3=1, WA3=1, WD3=12345678, RA1=1 in the same cycle -> RD1=12345678 before the edge; with BYPASS=0 -> RD1=0 until after the edge.
//  3 x0: WE3=1, WA3=0, WD3=0xFFFF_FFFF -> RD1(RA1=0)=0. ISSUE_EN with ISSUE_RD=0 -> BUSY1=0.
//  4 Scoreboard: ISSUE x7 -> BUSY2(RA2=7)=1 next cycle. WE3 x7 -> BUSY2=0 in the write cycle. ISSUE x7 and WE3 x7 together -> BUSY2 stays 1.
//  5 Debug write stall: DBG_REQ/WE=1, addr 3, data 0xA5 while WE3 is held 3 cycles -> no ACK during the stall. ACK one cycle after WE3 drops; then RD1(RA1=3)=0xA5.
//  6 Debug read: x2=87654321, DBG_REQ read addr 2 -> DBG_ACK=1 with DBG_RDATA=87654321. Drop DBG_REQ -> DBG_ACK=0 next cycle.
//    Abort test: drop DBG_REQ during a stall -> no write, FSM back in IDLE.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register_file_sb register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   dbg_state_t          : state encoding of the debug access FSM
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dbg_state_t;

endpackage

// File: rtl/rf_dbg_ctrl.sv
// Debug access controller for register_file_sb.
// Runs the 4-phase request/acknowledge handshake with the debugger and tells
// the register file when to perform the debug write or capture read data.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   dbg_req_i       debug request (held by the debugger until ack is seen)
//   dbg_we_i        1 = write access, 0 = read access
//   core_we_i       core write-back port is writing this cycle
//   dbg_wr_en_o     strobe: write debug data into the array at this edge
//   dbg_rd_cap_o    strobe: capture stored register value at this edge
//   dbg_ack_o       registered acknowledge
//   dbg_state_o     current FSM state, exported for observation
//
// Handshake: the debugger raises req and holds addr/we/wdata stable; the
// access happens in ACCESS and ack rises on the following cycle. ack stays
// high (read data held) until the debugger drops req, after which ack falls
// on the next cycle. Dropping req before ack aborts the access without effect.
module rf_dbg_ctrl
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dbg_req_i,
  input  logic       dbg_we_i,
  input  logic       core_we_i,
  output logic       dbg_wr_en_o,
  output logic       dbg_rd_cap_o,
  output logic       dbg_ack_o,
  output dbg_state_t dbg_state_o
);

  dbg_state_t state_q;
  logic       ack_q;
  logic       access_go;

  // A debug write yields to the core write port; reads never wait.
  assign access_go    = (state_q == ACCESS) && dbg_req_i && !(dbg_we_i && core_we_i);
  assign dbg_wr_en_o  = access_go && dbg_we_i;
  assign dbg_rd_cap_o = access_go && !dbg_we_i;
  assign dbg_ack_o    = ack_q;
  assign dbg_state_o  = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dbg_req_i) state_q <= ACCESS;
        end
        ACCESS: begin
          if (!dbg_req_i) begin
            state_q <= IDLE;          // aborted before completion
          end else if (access_go) begin
            state_q <= DONE;
            ack_q   <= 1'b1;
          end
        end
        DONE: begin
          if (!dbg_req_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Integer register file with pending-write scoreboard and debug access port.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   RA1/RA2, RD1/RD2    combinational read ports (x0 reads as zero)
//   BUSY1/BUSY2         register at RA1/RA2 has an outstanding producer
//   WE3/WA3/WD3         synchronous write-back port
//   ISSUE_EN/ISSUE_RD   marks ISSUE_RD as pending at the next edge
//   DBG_*               4-phase debug access port (see rf_dbg_ctrl)
//   dbg_state_o         debug FSM state, exported for observation
module register_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   RA1,
  input  logic [AW-1:0]   RA2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            BUSY1,
  output logic            BUSY2,
  input  logic            WE3,
  input  logic [AW-1:0]   WA3,
  input  logic [XLEN-1:0] WD3,
  input  logic            ISSUE_EN,
  input  logic [AW-1:0]   ISSUE_RD,
  input  logic            DBG_REQ,
  input  logic            DBG_WE,
  input  logic [AW-1:0]   DBG_ADDR,
  input  logic [XLEN-1:0] DBG_WDATA,
  output logic            DBG_ACK,
  output logic [XLEN-1:0] DBG_RDATA,
  output dbg_state_t      dbg_state_o
);

  localparam bit BYP = (BYPASS != 0);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic [XLEN-1:0]  dbg_rdata_q;
  logic             dbg_wr_en;
  logic             dbg_rd_cap;

  rf_dbg_ctrl u_dbg (
    .clk          (clk),
    .rst          (rst),
    .dbg_req_i    (DBG_REQ),
    .dbg_we_i     (DBG_WE),
    .core_we_i    (WE3),
    .dbg_wr_en_o  (dbg_wr_en),
    .dbg_rd_cap_o (dbg_rd_cap),
    .dbg_ack_o    (DBG_ACK),
    .dbg_state_o  (dbg_state_o)
  );

  // Storage. The debug controller only writes when WE3 is low, so the two
  // write sources never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (WE3) begin
      if (WA3 != '0) regs_q[WA3] <= WD3;
    end else if (dbg_wr_en) begin
      if (DBG_ADDR != '0) regs_q[DBG_ADDR] <= DBG_WDATA;
    end
  end

  // Debug read sees the stored value only, never the bypass path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dbg_rdata_q <= '0;
    else if (dbg_rd_cap) dbg_rdata_q <= regs_q[DBG_ADDR];
  end
  assign DBG_RDATA = dbg_rdata_q;

  // Scoreboard: a write-back retires the producer; an issue in the same cycle
  // to the same register starts a new producer, so the set is applied last.
  always_comb begin
    pending_d = pending_q;
    if (WE3) pending_d[WA3] = 1'b0;
    if (ISSUE_EN && (ISSUE_RD != '0)) pending_d[ISSUE_RD] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // Read ports with optional same-cycle forwarding of the write-back value.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (RA1 != '0) RD1 = (BYP && WE3 && (WA3 == RA1)) ? WD3 : regs_q[RA1];
    if (RA2 != '0) RD2 = (BYP && WE3 && (WA3 == RA2)) ? WD3 : regs_q[RA2];
  end

  // A register being written back this cycle is no longer busy for a bypassed
  // reader, unless a new producer is issued to it in the same cycle.
  assign BUSY1 = pending_q[RA1] &
                 ~(BYP && WE3 && (WA3 == RA1) && !(ISSUE_EN && (ISSUE_RD == RA1)));
  assign BUSY2 = pending_q[RA2] &
                 ~(BYP && WE3 && (WA3 == RA2) && !(ISSUE_EN && (ISSUE_RD == RA2)));

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;
  import rf_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0]   ra1, ra2, wa3, issue_rd, dbg_addr;
  logic [XLEN-1:0] wd3, dbg_wdata;
  logic            we3, issue_en, dbg_req, dbg_we;

  logic [XLEN-1:0] rd1, rd2, dbg_rdata, nb_rd1, nb_rd2, nb_dbg_rdata;
  logic            busy1, busy2, dbg_ack, nb_busy1, nb_busy2, nb_dbg_ack;
  dbg_state_t      dbg_state, nb_dbg_state;

  register_file_sb #(.XLEN(XLEN), .NREGS(32), .AW(AW), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .RA1(ra1), .RA2(ra2), .RD1(rd1), .RD2(rd2),
    .BUSY1(busy1), .BUSY2(busy2), .WE3(we3), .WA3(wa3), .WD3(wd3),
    .ISSUE_EN(issue_en), .ISSUE_RD(issue_rd), .DBG_REQ(dbg_req), .DBG_WE(dbg_we),
    .DBG_ADDR(dbg_addr), .DBG_WDATA(dbg_wdata), .DBG_ACK(dbg_ack),
    .DBG_RDATA(dbg_rdata), .dbg_state_o(dbg_state)
  );

  register_file_sb #(.XLEN(XLEN), .NREGS(32), .AW(AW), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .RA1(ra1), .RA2(ra2), .RD1(nb_rd1), .RD2(nb_rd2),
    .BUSY1(nb_busy1), .BUSY2(nb_busy2), .WE3(we3), .WA3(wa3), .WD3(wd3),
    .ISSUE_EN(issue_en), .ISSUE_RD(issue_rd), .DBG_REQ(dbg_req), .DBG_WE(dbg_we),
    .DBG_ADDR(dbg_addr), .DBG_WDATA(dbg_wdata), .DBG_ACK(nb_dbg_ack),
    .DBG_RDATA(nb_dbg_rdata), .dbg_state_o(nb_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [XLEN-1:0] act);
    logic [XLEN-1:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_val(input string name, input logic [XLEN-1:0] exp,
                            input logic [XLEN-1:0] act);
    exp_q.push_back(exp);
    check(name, act);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ra1 = '0; ra2 = '0; we3 = 1'b0; wa3 = '0; wd3 = '0;
    issue_en = 1'b0; issue_rd = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic            iss;
    logic [AW-1:0]   ird;
    logic [XLEN-1:0] e_rd1;
    logic [XLEN-1:0] e_rd2;
    logic            e_b1;
    logic            e_b2;
    logic [XLEN-1:0] e_nb1;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // we wa wd ra1 ra2 iss ird | rd1 rd2 busy1 busy2 rd1(no bypass)
    vecs[0]  = '{1'b1, 5'd1, 32'd12345678, 5'd1, 5'd0, 1'b0, 5'd0, 32'd12345678, 32'd0, 1'b0, 1'b0, 32'd0};
    vecs[1]  = '{1'b0, 5'd0, 32'd0, 5'd1, 5'd1, 1'b0, 5'd0, 32'd12345678, 32'd12345678, 1'b0, 1'b0, 32'd12345678};
    vecs[2]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd1, 1'b0, 5'd0, 32'd0, 32'd12345678, 1'b0, 1'b0, 32'd0};
    vecs[3]  = '{1'b0, 5'd0, 32'd0, 5'd0, 5'd1, 1'b1, 5'd0, 32'd0, 32'd12345678, 1'b0, 1'b0, 32'd0};
    vecs[4]  = '{1'b0, 5'd0, 32'd0, 5'd0, 5'd7, 1'b1, 5'd7, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0};
    vecs[5]  = '{1'b0, 5'd0, 32'd0, 5'd1, 5'd7, 1'b0, 5'd0, 32'd12345678, 32'd0, 1'b0, 1'b1, 32'd12345678};
    vecs[6]  = '{1'b1, 5'd7, 32'h77, 5'd1, 5'd7, 1'b0, 5'd0, 32'd12345678, 32'h77, 1'b0, 1'b0, 32'd12345678};
    vecs[7]  = '{1'b0, 5'd0, 32'd0, 5'd1, 5'd7, 1'b0, 5'd0, 32'd12345678, 32'h77, 1'b0, 1'b0, 32'd12345678};
    vecs[8]  = '{1'b0, 5'd0, 32'd0, 5'd1, 5'd7, 1'b1, 5'd7, 32'd12345678, 32'h77, 1'b0, 1'b0, 32'd12345678};
    vecs[9]  = '{1'b1, 5'd7, 32'h88, 5'd1, 5'd7, 1'b1, 5'd7, 32'd12345678, 32'h88, 1'b0, 1'b1, 32'd12345678};
    vecs[10] = '{1'b0, 5'd0, 32'd0, 5'd1, 5'd7, 1'b0, 5'd0, 32'd12345678, 32'h88, 1'b0, 1'b1, 32'd12345678};
    vecs[11] = '{1'b1, 5'd2, 32'd87654321, 5'd2, 5'd7, 1'b0, 5'd0, 32'd87654321, 32'h88, 1'b0, 1'b1, 32'd0};
    vecs[12] = '{1'b0, 5'd0, 32'd0, 5'd2, 5'd2, 1'b0, 5'd0, 32'd87654321, 32'd87654321, 1'b0, 1'b0, 32'd87654321};
  end

  // ---------------- test sequence ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    #12;
    expect_val("reset_rd1", '0, rd1);
    expect_val("reset_ack", '0, {31'd0, dbg_ack});
    expect_val("reset_rdata", '0, dbg_rdata);
    expect_val("reset_state", IDLE, {30'd0, dbg_state});
    rst = 1'b0;
    tick();

    // Table: reads, bypass, x0, scoreboard.
    for (int i = 0; i < 13; i++) begin
      we3 = vecs[i].we; wa3 = vecs[i].wa; wd3 = vecs[i].wd;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      issue_en = vecs[i].iss; issue_rd = vecs[i].ird;
      #1;
      expect_val($sformatf("v%0d_rd1", i), vecs[i].e_rd1, rd1);
      expect_val($sformatf("v%0d_rd2", i), vecs[i].e_rd2, rd2);
      expect_val($sformatf("v%0d_busy1", i), {31'd0, vecs[i].e_b1}, {31'd0, busy1});
      expect_val($sformatf("v%0d_busy2", i), {31'd0, vecs[i].e_b2}, {31'd0, busy2});
      expect_val($sformatf("v%0d_nb_rd1", i), vecs[i].e_nb1, nb_rd1);
      tick();
    end
    idle_inputs();

    // Debug read of x2.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd2;
    tick();
    expect_val("dbgrd_ack_access", '0, {31'd0, dbg_ack});
    tick();
    expect_val("dbgrd_ack", 32'd1, {31'd0, dbg_ack});
    expect_val("dbgrd_rdata", 32'd87654321, dbg_rdata);
    tick();
    expect_val("dbgrd_ack_held", 32'd1, {31'd0, dbg_ack});
    dbg_req = 1'b0;
    tick();
    expect_val("dbgrd_ack_drop", '0, {31'd0, dbg_ack});
    expect_val("dbgrd_state_idle", IDLE, {30'd0, dbg_state});

    // Debug write to x3 stalled by three cycles of core writes to x9.
    we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h99;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'hA5;
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_val($sformatf("dbgwr_stall_ack%0d", c), '0, {31'd0, dbg_ack});
    end
    we3 = 1'b0;
    tick();
    expect_val("dbgwr_ack", 32'd1, {31'd0, dbg_ack});
    ra1 = 5'd3; ra2 = 5'd9;
    #1;
    expect_val("dbgwr_x3", 32'hA5, rd1);
    expect_val("dbgwr_core_x9", 32'h99, rd2);
    dbg_req = 1'b0;
    tick();
    expect_val("dbgwr_ack_drop", '0, {31'd0, dbg_ack});

    // Abort: debug write to x4 dropped while stalled.
    we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h99;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'h55;
    tick();
    tick();
    expect_val("abort_state_access", ACCESS, {30'd0, dbg_state});
    dbg_req = 1'b0; we3 = 1'b0;
    tick();
    tick();
    ra1 = 5'd4;
    #1;
    expect_val("abort_state_idle", IDLE, {30'd0, dbg_state});
    expect_val("abort_ack", '0, {31'd0, dbg_ack});
    expect_val("abort_x4", '0, rd1);
    idle_inputs();

    // Asynchronous reset mid-run while a debug access is complete.
    we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hDEAD; issue_en = 1'b1; issue_rd = 5'd5;
    tick();
    idle_inputs();
    ra1 = 5'd5;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
    tick();
    tick();
    expect_val("pre_rst_rd1", 32'hDEAD, rd1);
    expect_val("pre_rst_busy1", 32'd1, {31'd0, busy1});
    expect_val("pre_rst_ack", 32'd1, {31'd0, dbg_ack});
    expect_val("pre_rst_rdata", 32'hDEAD, dbg_rdata);
    rst = 1'b1;
    #1;
    expect_val("rst_rd1", '0, rd1);
    expect_val("rst_busy1", '0, {31'd0, busy1});
    expect_val("rst_ack", '0, {31'd0, dbg_ack});
    expect_val("rst_rdata", '0, dbg_rdata);
    expect_val("rst_state", IDLE, {30'd0, dbg_state});
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
